// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch/decode sequencer driving PC pulses and execute handshake
module fetch_controller #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              incPC,
  output logic              loadPC,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] ir,
  output logic              exec_valid,
  input  logic              exec_done,
  output logic              halted
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_t;
  localparam logic [1:0] OP_JMP = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;
  state_t state, state_n;
  logic [DATA_W-1:0] ir_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [1:0] op, op_n;
  assign op = ir[DATA_W-1 -: 2];
  assign op_n = ir_n[DATA_W-1 -: 2];
  // next state, next instruction register and next fetch address
  always_comb begin
    state_n = state;
    ir_n = ir;
    mem_addr_n = mem_addr;
    unique case (state)
      IDLE: begin
        state_n = FETCH;
        mem_addr_n = pc_addr;
      end
      FETCH: begin
        state_n = mem_ack ? DECODE : FETCH;
        ir_n = mem_ack ? mem_data : ir;
      end
      DECODE: state_n = op == OP_HALT ? HALT : op == OP_JMP ? IDLE : EXEC;
      EXEC: state_n = exec_done ? IDLE : EXEC;
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end
  // state and all outputs registered from the next state so outputs are glitch-free Moore
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ir <= '0;
      mem_addr <= '0;
      mem_req <= 1'b0;
      incPC <= 1'b0;
      loadPC <= 1'b0;
      address <= '0;
      exec_valid <= 1'b0;
      halted <= 1'b0;
    end else begin
      state <= state_n;
      ir <= ir_n;
      mem_addr <= mem_addr_n;
      mem_req <= state_n == FETCH;
      incPC <= state_n == DECODE && !op_n[1];
      loadPC <= state_n == DECODE && op_n == OP_JMP;
      address <= state_n == DECODE && op_n == OP_JMP ? ir_n[ADDR_W-1:0] : address;
      exec_valid <= state_n == EXEC;
      halted <= state_n == HALT;
    end
  end
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: directed checks of fetch_controller with memory, PC and execute models
module tb_fetch_controller;
  logic clk = 0, reset = 1;
  logic [5:0] pc_addr = 0, mem_addr, address;
  logic mem_req, mem_ack = 0, incPC, loadPC, exec_valid, exec_done = 0, halted;
  logic [7:0] mem_data = 0, ir;
  logic [7:0] mem [64];
  int compared = 0, mismatched = 0;
  int ack_delay = 0, exec_delay = 0, rc = 0, dc = 0;
  int inc_cnt = 0, ld_cnt = 0, ev_cnt = 0, viol = 0;
  logic noise = 0, p_inc = 0, p_ld = 0, p_req = 0;
  logic [5:0] p_addr = 0;

  fetch_controller dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data), .incPC(incPC), .loadPC(loadPC), .address(address),
    .ir(ir), .exec_valid(exec_valid), .exec_done(exec_done), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    inc_cnt = 0;
    ld_cnt = 0;
    ev_cnt = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " outs"}, {mem_req, incPC, loadPC, exec_valid, halted}, 0);
    check({tag, " ir"}, ir, 0);
    check({tag, " mem_addr"}, mem_addr, 0);
    check({tag, " address"}, address, 0);
  endtask

  // PC model, memory responder, execute responder and PC pulse-rule monitor
  initial forever begin
    @(negedge clk);
    if (incPC && loadPC) viol++;
    if (incPC && p_inc) viol++;
    if (loadPC && p_ld) viol++;
    if (mem_req && p_req && mem_addr != p_addr) viol++;
    inc_cnt += int'(incPC);
    ld_cnt += int'(loadPC);
    ev_cnt += int'(exec_valid);
    p_inc = incPC;
    p_ld = loadPC;
    p_req = mem_req;
    p_addr = mem_addr;
    if (!reset) pc_addr = 0;
    else if (incPC) pc_addr = pc_addr + 6'd1;
    else if (loadPC) pc_addr = address;
    rc = mem_req ? rc + 1 : 0;
    dc = exec_valid ? dc + 1 : 0;
    mem_ack = noise ? 1'($urandom) : mem_req && rc > ack_delay;
    exec_done = noise ? 1'($urandom) : exec_valid && dc > exec_delay;
    mem_data = mem[mem_addr];
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h05;
    mem[1] = 8'hAA;
    mem[42] = 8'hC0;
    #2 reset = 0;
    #1 check_all_zero("reset");
    step();
    reset = 1;
    clear_counts();
    step();
    check("t1 fetch req", mem_req, 1);
    check("t1 fetch addr", mem_addr, 0);
    step();
    check("t1 ir", ir, 8'h05);
    check("t1 incPC", incPC, 1);
    check("t1 ev early", exec_valid, 0);
    step();
    check("t1 exec_valid", exec_valid, 1);
    check("t1 inc drop", incPC, 0);
    step();
    check("t1 idle", {exec_valid, mem_req}, 0);
    ack_delay = 5;
    step();
    check("t2 addr pc1", mem_addr, 1);
    check("t2 req", mem_req, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2 req held", mem_req, 1);
      check("t2 no pulse", {incPC, loadPC}, 0);
    end
    ack_delay = 0;
    step();
    check("t3 ir", ir, 8'hAA);
    check("t3 loadPC", loadPC, 1);
    check("t3 incPC", incPC, 0);
    check("t3 address", address, 6'h2A);
    step();
    check("t3 load drop", loadPC, 0);
    check("t3 address hold", address, 6'h2A);
    step();
    check("t3 jump fetch", mem_addr, 6'h2A);
    step();
    check("t4 ir", ir, 8'hC0);
    check("t4 no pulse", {incPC, loadPC}, 0);
    step();
    check("t4 halted", halted, 1);
    noise = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4 halt hold", {halted, mem_req, incPC, loadPC, exec_valid}, 5'b10000);
    end
    noise = 0;
    check("t1-4 inc count", inc_cnt, 1);
    check("t1-4 load count", ld_cnt, 1);
    check("t1-4 ev count", ev_cnt, 1);
    reset = 0;
    step();
    reset = 1;
    exec_delay = 1000;
    step();
    step();
    step();
    check("t5 in exec", exec_valid, 1);
    reset = 0;
    #1 check_all_zero("t5 async");
    step();
    reset = 1;
    exec_delay = 0;
    clear_counts();
    step();
    check("t5 restart fetch", {mem_req, mem_addr}, {1'b1, 6'd0});
    check("t5 no spurious inc", inc_cnt, 0);
    reset = 0;
    step();
    for (int i = 0; i < 64; i++) mem[i] = 8'h05;
    reset = 1;
    clear_counts();
    for (int i = 0; i < 257; i++) step();
    check("t6 inc count", inc_cnt, 64);
    check("t6 ev count", ev_cnt, 64);
    check("t6 wrap fetch", {mem_req, mem_addr}, {1'b1, 6'd0});
    check("pulse rule violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
